// File: rtl/clk_btn_pkg.sv
// -----------------------------------------------------------------------------
// clk_btn_pkg
// Shared definitions for the time-setting input conditioner:
//   - chan_state_e : per-button channel state
//   - cnt_width()  : counter width able to hold the largest timing parameter
//   - BTN_*        : bit positions of the four buttons in the internal vectors
// -----------------------------------------------------------------------------
package clk_btn_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DB_PRESS = 3'd1,
      DELAY    = 3'd2,
      REPEAT   = 3'd3,
      DB_REL   = 3'd4
   } chan_state_e;

   localparam int BTN_INC_HR  = 0;
   localparam int BTN_DEC_HR  = 1;
   localparam int BTN_INC_MIN = 2;
   localparam int BTN_DEC_MIN = 3;
   localparam int NUM_BTN     = 4;

   // One spare bit above $clog2 keeps the width valid even for tiny parameters.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/clk_btn_cond_if.sv
// -----------------------------------------------------------------------------
// clk_btn_cond_if
// Bundles the raw switch/button inputs and the conditioned outputs.
//   master : drives the raw inputs, observes the conditioned outputs
//   slave  : the conditioner itself
// -----------------------------------------------------------------------------
interface clk_btn_cond_if;
   logic time_set_raw;
   logic inc_hr_raw;
   logic dec_hr_raw;
   logic inc_min_raw;
   logic dec_min_raw;
   logic time_set;
   logic inc_hr;
   logic dec_hr;
   logic inc_min;
   logic dec_min;

   modport master (
      output time_set_raw, inc_hr_raw, dec_hr_raw, inc_min_raw, dec_min_raw,
      input  time_set, inc_hr, dec_hr, inc_min, dec_min
   );

   modport slave (
      input  time_set_raw, inc_hr_raw, dec_hr_raw, inc_min_raw, dec_min_raw,
      output time_set, inc_hr, dec_hr, inc_min, dec_min
   );
endinterface

// File: rtl/clk_btn_chan.sv
// -----------------------------------------------------------------------------
// clk_btn_chan
// One button channel: 2-flop synchroniser, debounce / auto-repeat FSM and its
// counter. pulse_req is combinational; the top registers it.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   btn_raw     : raw active-high button
//   enable      : synchronised time_set level; low holds the channel idle
//   pulse_req   : single-cycle request for an output pulse
// -----------------------------------------------------------------------------
module clk_btn_chan
   import clk_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   input  logic enable,
   output logic pulse_req
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync1_q;
   logic          sync2_q;
   chan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Two-flop synchroniser for the raw button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Channel state and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and pulse-request logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_req = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (sync2_q) state_d = DB_PRESS;
               else         state_d = IDLE;
            end
            DB_PRESS: begin
               if (!sync2_q) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  pulse_req = 1'b1;
                  cnt_d     = '0;
                  state_d   = DELAY;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            DELAY: begin
               if (!sync2_q) begin
                  state_d = DB_REL;
                  cnt_d   = '0;
               end else if (cnt_q == DLY_LAST) begin
                  pulse_req = 1'b1;
                  cnt_d     = '0;
                  state_d   = REPEAT;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            REPEAT: begin
               if (!sync2_q) begin
                  state_d = DB_REL;
                  cnt_d   = '0;
               end else if (cnt_q == PER_LAST) begin
                  pulse_req = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            DB_REL: begin
               // A high sample here is release bounce: the hold resumes
               // in REPEAT rather than producing a fresh first pulse.
               if (sync2_q) begin
                  state_d = REPEAT;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/clk_btn_cond.sv
// -----------------------------------------------------------------------------
// clk_btn_cond
// Input conditioner for the clock's time-setting controls.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn_if     : slave side of clk_btn_cond_if
//                raw switch/buttons in; time_set level and registered
//                one-cycle inc/dec hour/minute pulses out
// The switch is only synchronised; buttons go through clk_btn_chan. Opposite
// requests on the same field in the same cycle cancel each other.
// -----------------------------------------------------------------------------
module clk_btn_cond
   import clk_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 20_000_000
) (
   input  logic           clk,
   input  logic           rst_n,
   clk_btn_cond_if.slave  btn_if
);

   logic                 ts_sync1_q;
   logic                 ts_sync2_q;
   logic [NUM_BTN-1:0]   btn_raw_s;
   logic [NUM_BTN-1:0]   req_s;
   logic [NUM_BTN-1:0]   pulse_d, pulse_q;
   logic                 hr_conflict_s;
   logic                 min_conflict_s;

   assign btn_raw_s[BTN_INC_HR]  = btn_if.inc_hr_raw;
   assign btn_raw_s[BTN_DEC_HR]  = btn_if.dec_hr_raw;
   assign btn_raw_s[BTN_INC_MIN] = btn_if.inc_min_raw;
   assign btn_raw_s[BTN_DEC_MIN] = btn_if.dec_min_raw;

   // Two-flop synchroniser for the time_set switch (no debounce).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_sync1_q <= 1'b0;
         ts_sync2_q <= 1'b0;
      end else begin
         ts_sync1_q <= btn_if.time_set_raw;
         ts_sync2_q <= ts_sync1_q;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      clk_btn_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_raw   (btn_raw_s[i]),
         .enable    (ts_sync2_q),
         .pulse_req (req_s[i])
      );
   end

   // Conflict masking: simultaneous inc and dec on one field are both dropped.
   always_comb begin
      hr_conflict_s          = req_s[BTN_INC_HR]  & req_s[BTN_DEC_HR];
      min_conflict_s         = req_s[BTN_INC_MIN] & req_s[BTN_DEC_MIN];
      pulse_d                = '0;
      pulse_d[BTN_INC_HR]    = req_s[BTN_INC_HR]  & ~hr_conflict_s;
      pulse_d[BTN_DEC_HR]    = req_s[BTN_DEC_HR]  & ~hr_conflict_s;
      pulse_d[BTN_INC_MIN]   = req_s[BTN_INC_MIN] & ~min_conflict_s;
      pulse_d[BTN_DEC_MIN]   = req_s[BTN_DEC_MIN] & ~min_conflict_s;
   end

   // Output pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_q <= '0;
      end else begin
         pulse_q <= pulse_d;
      end
   end

   assign btn_if.time_set = ts_sync2_q;
   assign btn_if.inc_hr   = pulse_q[BTN_INC_HR];
   assign btn_if.dec_hr   = pulse_q[BTN_DEC_HR];
   assign btn_if.inc_min  = pulse_q[BTN_INC_MIN];
   assign btn_if.dec_min  = pulse_q[BTN_DEC_MIN];

endmodule

// File: tb/tb_clk_btn_cond.sv
// -----------------------------------------------------------------------------
// tb_clk_btn_cond
// Directed bench for clk_btn_cond with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Stimulus pushes expected (cycle, pulse mask) entries into a
// queue; a monitor on the falling edge pops and compares every pulse seen.
// Cycle N is the interval after the N-th rising edge. Mask bit order:
// {dec_min, inc_min, dec_hr, inc_hr}.
// -----------------------------------------------------------------------------
module tb_clk_btn_cond;

   typedef struct {
      int         cyc;
      logic [3:0] mask;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;
   exp_t exp_q[$];

   clk_btn_cond_if bus ();

   clk_btn_cond #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_if (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] act_mask();
      return {bus.dec_min, bus.inc_min, bus.dec_hr, bus.inc_hr};
   endfunction

   task automatic expect_pulse(input int c, input logic [3:0] m);
      exp_t e;
      e.cyc  = c;
      e.mask = m;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: overdue entries are missed pulses; every pulse seen
   // must match the head of the queue in both cycle and mask.
   always @(negedge clk) begin
      exp_t       e;
      logic [3:0] act;
      act = act_mask();
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL missed_pulse: got none expected mask %b at cycle %0d", e.mask, e.cyc);
      end
      if (act != 4'b0000) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got mask %b at cycle %0d expected none", act, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.mask != act) begin
               bad++;
               $display("FAIL pulse: got mask %b at cycle %0d expected mask %b at cycle %0d",
                        act, cyc, e.mask, e.cyc);
            end
         end
      end
   end

   initial begin
      int e;
      total            = 0;
      bad              = 0;
      rst_n            = 1'b0;
      bus.time_set_raw = 1'b0;
      bus.inc_hr_raw   = 1'b0;
      bus.dec_hr_raw   = 1'b0;
      bus.inc_min_raw  = 1'b0;
      bus.dec_min_raw  = 1'b0;

      // Reset state
      ticks(3);
      check("reset_pulses", {28'd0, act_mask()}, 32'd0);
      check("reset_time_set", {31'd0, bus.time_set}, 32'd0);
      rst_n = 1'b1;
      ticks(2);

      // time_set: 2-cycle latency
      bus.time_set_raw = 1'b1;
      e = cyc + 1;
      ticks(1);
      check("time_set_cyc_e", {31'd0, bus.time_set}, 32'd0);
      ticks(1);
      check("time_set_cyc_e1", {31'd0, bus.time_set}, 32'd1);
      ticks(3);

      // Clean press on inc_min
      e = cyc + 1;
      bus.inc_min_raw = 1'b1;
      expect_pulse(e + 6,  4'b0100);
      expect_pulse(e + 16, 4'b0100);
      expect_pulse(e + 19, 4'b0100);
      expect_pulse(e + 22, 4'b0100);
      expect_pulse(e + 25, 4'b0100);
      expect_pulse(e + 28, 4'b0100);
      ticks(28);
      bus.inc_min_raw = 1'b0;
      ticks(12);

      // Press bounce on inc_hr: samples 1,0,1,1,0 then high
      e = cyc + 1;
      bus.inc_hr_raw = 1'b1; ticks(1);
      bus.inc_hr_raw = 1'b0; ticks(1);
      bus.inc_hr_raw = 1'b1; ticks(1);
      bus.inc_hr_raw = 1'b1; ticks(1);
      bus.inc_hr_raw = 1'b0; ticks(1);
      bus.inc_hr_raw = 1'b1;
      expect_pulse(e + 5 + 6, 4'b0001);
      ticks(9);
      bus.inc_hr_raw = 1'b0;
      ticks(12);

      // Conflict on hour, minute unaffected
      e = cyc + 1;
      bus.inc_hr_raw  = 1'b1;
      bus.dec_hr_raw  = 1'b1;
      bus.inc_min_raw = 1'b1;
      expect_pulse(e + 6,  4'b0100);
      expect_pulse(e + 16, 4'b0100);
      expect_pulse(e + 19, 4'b0100);
      ticks(20);
      bus.inc_hr_raw  = 1'b0;
      bus.dec_hr_raw  = 1'b0;
      bus.inc_min_raw = 1'b0;
      ticks(12);

      // Simultaneous hour and minute pulses are legal
      e = cyc + 1;
      bus.inc_hr_raw  = 1'b1;
      bus.dec_min_raw = 1'b1;
      expect_pulse(e + 6, 4'b1001);
      ticks(8);
      bus.inc_hr_raw  = 1'b0;
      bus.dec_min_raw = 1'b0;
      ticks(12);

      // Gating: switch low, button held -> nothing
      bus.time_set_raw = 1'b0;
      ticks(4);
      check("gated_time_set", {31'd0, bus.time_set}, 32'd0);
      bus.inc_hr_raw = 1'b1;
      ticks(15);
      e = cyc + 1;
      bus.time_set_raw = 1'b1;
      expect_pulse(e + 6, 4'b0001);
      ticks(8);
      bus.inc_hr_raw = 1'b0;
      ticks(12);

      // Release bounce on dec_min
      e = cyc + 1;
      bus.dec_min_raw = 1'b1;
      expect_pulse(e + 6,  4'b1000);
      expect_pulse(e + 16, 4'b1000);
      expect_pulse(e + 19, 4'b1000);
      expect_pulse(e + 27, 4'b1000);
      expect_pulse(e + 30, 4'b1000);
      expect_pulse(e + 33, 4'b1000);
      ticks(20);
      bus.dec_min_raw = 1'b0;
      ticks(2);
      bus.dec_min_raw = 1'b1;
      ticks(10);
      bus.dec_min_raw = 1'b0;
      ticks(12);

      // Reset mid-hold while a pulse is high
      e = cyc + 1;
      bus.inc_min_raw = 1'b1;
      expect_pulse(e + 6, 4'b0100);
      ticks(7);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_pulses", {28'd0, act_mask()}, 32'd0);
      check("async_reset_time_set", {31'd0, bus.time_set}, 32'd0);
      ticks(2);
      rst_n = 1'b1;
      e = cyc + 1;
      expect_pulse(e + 6, 4'b0100);
      ticks(8);
      bus.inc_min_raw = 1'b0;
      ticks(20);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
